// File: rtl/fb_reader.sv
// fb_reader: Wishbone burst master that streams the framebuffer in raster order into the pixel FIFO.
// A burst is only launched when the FIFO guarantees room for all of it; frame_sync restarts at pixel 0.
module fb_reader #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter int          BURST    = 16,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic        wshb_ifm_clk,
    input  logic        wshb_ifm_rst,
    output logic [31:0] wshb_ifm_adr,
    input  logic [31:0] wshb_ifm_dat_sm,
    input  logic        wshb_ifm_ack,
    output logic        wshb_ifm_cyc,
    output logic        wshb_ifm_stb,
    output logic        wshb_ifm_we,
    output logic [3:0]  wshb_ifm_sel,
    output logic [2:0]  wshb_ifm_cti,
    output logic [1:0]  wshb_ifm_bte,
    input  logic        fifo_walmost_full,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    input  logic        frame_sync,
    output logic        frame_done
);

    localparam int NPIX = HDISP * VDISP;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BW   = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [2:0] CTI_IDLE = 3'b000;
    localparam logic [2:0] CTI_INC  = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    if ((NPIX % BURST) != 0) begin : g_burst_check
        $error("fb_reader: HDISP*VDISP must be a multiple of BURST");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   pix;
    logic [PW-1:0]   pix_next;
    logic [BW-1:0]   beat;
    logic            pending;
    logic            beat_ack;
    logic            last_pix;
    logic            restart;

    assign beat_ack = (state == S_BURST) && wshb_ifm_ack;
    assign last_pix = (pix == PW'(NPIX - 1));
    assign restart  = (state == S_IDLE) && (frame_sync || pending);

    // The address register tracks the next pixel so it is already valid on the first beat.
    always_comb begin
        pix_next = pix;
        if (restart) begin
            pix_next = '0;
        end else if (beat_ack) begin
            pix_next = last_pix ? '0 : pix + PW'(1);
        end
    end

    always_ff @(posedge wshb_ifm_clk) begin
        if (wshb_ifm_rst) begin
            state        <= S_IDLE;
            pix          <= '0;
            beat         <= '0;
            pending      <= 1'b0;
            wshb_ifm_adr <= BASE_ADR;
            wshb_ifm_cyc <= 1'b0;
            wshb_ifm_cti <= CTI_IDLE;
            frame_done   <= 1'b0;
        end else begin
            pix          <= pix_next;
            wshb_ifm_adr <= BASE_ADR + (32'(pix_next) << 2);
            frame_done   <= beat_ack && last_pix;
            case (state)
                S_IDLE: begin
                    if (frame_sync || pending) begin
                        pending <= 1'b0;
                    end else if (!fifo_walmost_full) begin
                        state        <= S_BURST;
                        beat         <= '0;
                        wshb_ifm_cyc <= 1'b1;
                        wshb_ifm_cti <= (BURST == 1) ? CTI_END : CTI_INC;
                    end
                end
                S_BURST: begin
                    // A sync request never aborts a burst; it is deferred to the next idle cycle.
                    if (frame_sync) begin
                        pending <= 1'b1;
                    end
                    if (wshb_ifm_ack) begin
                        if (beat == BW'(BURST - 1)) begin
                            state        <= S_IDLE;
                            beat         <= '0;
                            wshb_ifm_cyc <= 1'b0;
                            wshb_ifm_cti <= CTI_IDLE;
                        end else begin
                            beat         <= beat + BW'(1);
                            wshb_ifm_cti <= ((beat + BW'(1)) == BW'(BURST - 1)) ? CTI_END : CTI_INC;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign wshb_ifm_stb = wshb_ifm_cyc;
    assign wshb_ifm_we  = 1'b0;
    assign wshb_ifm_sel = 4'hF;
    assign wshb_ifm_bte = 2'b00;

    assign fifo_write = wshb_ifm_cyc && wshb_ifm_ack;
    assign fifo_wdata = wshb_ifm_dat_sm;

endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: directed vector table plus multi-cycle burst sequences for fb_reader.
// Uses a reduced 32x4 frame so whole-frame wrap and frame_done are reachable quickly.
module tb_fb_reader;

    localparam int          HDISP = 32;
    localparam int          VDISP = 4;
    localparam int          BURST = 16;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          NPIX  = HDISP * VDISP;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_sm;
    logic        ack;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        af;
    logic        fw;
    logic [31:0] wdata;
    logic        fs;
    logic        fd;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic        af;
        logic        ack;
        logic        fs;
        logic        ecyc;
        logic [2:0]  ecti;
        logic [31:0] eadr;
        logic        efw;
        logic [31:0] edata;
        logic        efd;
    } vec_t;

    vec_t vecs[$];

    fb_reader #(
        .HDISP(HDISP),
        .VDISP(VDISP),
        .BURST(BURST),
        .BASE_ADR(BASE)
    ) dut (
        .wshb_ifm_clk(clk),
        .wshb_ifm_rst(rst),
        .wshb_ifm_adr(adr),
        .wshb_ifm_dat_sm(dat_sm),
        .wshb_ifm_ack(ack),
        .wshb_ifm_cyc(cyc),
        .wshb_ifm_stb(stb),
        .wshb_ifm_we(we),
        .wshb_ifm_sel(sel),
        .wshb_ifm_cti(cti),
        .wshb_ifm_bte(bte),
        .fifo_walmost_full(af),
        .fifo_write(fw),
        .fifo_wdata(wdata),
        .frame_sync(fs),
        .frame_done(fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int p);
        return 32'hA500_003C ^ (32'(p) * 32'h0001_0101);
    endfunction

    // Memory model: the slave returns the word stored at whatever address is presented.
    always_comb dat_sm = mem_word(int'((adr - BASE) >> 2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic k, input logic s);
        rst = r;
        af  = a;
        ack = k;
        fs  = s;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic a, input logic k, input logic s,
                           input logic ecyc, input logic [2:0] ecti, input logic [31:0] eadr,
                           input logic efw, input logic [31:0] edata, input logic efd);
        vec_t v;
        v.rst = r; v.af = a; v.ack = k; v.fs = s;
        v.ecyc = ecyc; v.ecti = ecti; v.eadr = eadr;
        v.efw = efw; v.edata = edata; v.efd = efd;
        vecs.push_back(v);
    endtask

    // One burst from startPix with 0..maxWait wait states per beat; frame_sync pulsed on syncBeat.
    task automatic run_burst(input int startPix, input int maxWait, input int syncBeat, input bit inBurst);
        int   n;
        int   w;
        int   p;
        int   writes;
        logic exp_fd;
        n      = 0;
        writes = 0;
        exp_fd = 1'b0;
        if (!inBurst) begin
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            while (cyc !== 1'b1 && n < 40) begin
                tick();
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                n++;
            end
        end
        checkOutput("burst_start_cyc", cyc, 1);
        if (cyc !== 1'b1) return;
        for (int b = 0; b < BURST; b++) begin
            p = (startPix + b) % NPIX;
            w = int'($urandom_range(maxWait, 0));
            for (int k = 0; k < w; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                checkOutput("wait_no_write", fw, 0);
                checkOutput("wait_frame_done", fd, exp_fd);
                exp_fd = 1'b0;
                tick();
            end
            applyStimulus(1'b0, 1'b1, 1'b1, b == syncBeat);
            checkOutput($sformatf("beat%0d_adr", b), adr, BASE + 32'(4 * p));
            checkOutput($sformatf("beat%0d_cti", b), cti, (b == BURST - 1) ? 3'b111 : 3'b010);
            checkOutput($sformatf("beat%0d_stb", b), stb, 1);
            checkOutput($sformatf("beat%0d_write", b), fw, 1);
            checkOutput($sformatf("beat%0d_data", b), wdata, mem_word(p));
            checkOutput($sformatf("beat%0d_frame_done", b), fd, exp_fd);
            if (fw === 1'b1) writes++;
            exp_fd = (p == NPIX - 1);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_burst_cyc", cyc, 0);
        checkOutput("post_burst_cti", cti, 0);
        checkOutput("post_burst_frame_done", fd, exp_fd);
        checkOutput("burst_writes", writes, BURST);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;

        add_vec(1, 1, 0, 0, 0, 3'b000, BASE, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 3'b000, BASE, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 3'b000, BASE, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 3'b000, BASE, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            add_vec(0, 1, 1, 0, 1, (k == 15) ? 3'b111 : 3'b010, BASE + 32'(4 * k), 1, mem_word(k), 0);
        end
        add_vec(0, 0, 1, 0, 0, 3'b000, BASE + 32'h40, 0, 0, 0);
        add_vec(0, 1, 0, 0, 1, 3'b010, BASE + 32'h40, 0, 0, 0);
        for (int k = 16; k < 21; k++) begin
            add_vec(0, 1, 1, 0, 1, 3'b010, BASE + 32'(4 * k), 1, mem_word(k), 0);
        end
        add_vec(1, 1, 1, 0, 1, 3'b010, BASE + 32'(4 * 21), 1, mem_word(21), 0);
        add_vec(0, 1, 1, 0, 0, 3'b000, BASE, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 3'b000, BASE, 0, 0, 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        foreach (vecs[i]) begin
            tick();
            applyStimulus(vecs[i].rst, vecs[i].af, vecs[i].ack, vecs[i].fs);
            checkOutput($sformatf("vec%0d_cyc", i), cyc, vecs[i].ecyc);
            checkOutput($sformatf("vec%0d_stb", i), stb, vecs[i].ecyc);
            checkOutput($sformatf("vec%0d_cti", i), cti, vecs[i].ecti);
            checkOutput($sformatf("vec%0d_adr", i), adr, vecs[i].eadr);
            checkOutput($sformatf("vec%0d_write", i), fw, vecs[i].efw);
            checkOutput($sformatf("vec%0d_frame_done", i), fd, vecs[i].efd);
            if (vecs[i].efw) begin
                checkOutput($sformatf("vec%0d_data", i), wdata, vecs[i].edata);
            end
        end

        run_burst(0, 3, -1, 1'b0);
        run_burst(16, 3, -1, 1'b0);
        run_burst(32, 0, 5, 1'b0);
        run_burst(0, 1, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            tick();
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("held_full_cyc", cyc, 0);
            checkOutput("held_full_write", fw, 0);
        end
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("release_same_cycle_cyc", cyc, 0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("release_next_edge_cyc", cyc, 1);
        run_burst(16, 2, -1, 1'b1);

        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        run_burst(0, 0, -1, 1'b0);

        for (int b = 1; b < NPIX / BURST; b++) begin
            run_burst(16 * b, 2, -1, 1'b0);
        end
        run_burst(0, 0, -1, 1'b0);

        checkOutput("const_we", we, 0);
        checkOutput("const_sel", sel, 4'hF);
        checkOutput("const_bte", bte, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
